cursor_overlay_pipe: RTL
========================

Name: cursor_overlay_pipe

Overview:
- Pipelined, parametrised cursor compositor. It sits between the frame-buffer RGB output and the TMDS encoders.
- Overlays NUM_CURSORS independent cursors on the scaled pixel stream. Each cursor has its own position, colour and enable.
- Supports selectable shapes (full-line crosshair, short crosshair, box outline) and frame-synchronous blinking.
- Delays the video timing signals so they stay aligned with the composited pixel.

Parameters:
- NUM_CURSORS, 2, number of overlaid cursors; index 0 has highest priority.
- H_WIDTH, 10, width of horizontal coordinate.
- V_WIDTH, 9, width of vertical coordinate.
- THICK, 1, half-thickness T in pixels; a stroke covers distance 0..T.
- ARM_LEN, 8, arm length / box half-size L in pixels; must be > THICK.
- BLINK_FRAMES, 30, frames per blink phase; must be >= 1.

Ports:
- clk_pixel_in  input  1  pixel clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- hcount_in  input  H_WIDTH  scaled horizontal pixel coordinate.
- vcount_in  input  V_WIDTH  scaled vertical pixel coordinate.
- ad_in  input  1  active draw.
- hs_in  input  1  horizontal sync.
- vs_in  input  1  vertical sync.
- nf_in  input  1  single-cycle new-frame pulse.
- red_in, green_in, blue_in  input  8 each  background (frame-buffer) pixel.
- cursor_x_in  input  NUM_CURSORS*H_WIDTH  packed x; cursor i at bits [i*H_WIDTH +: H_WIDTH].
- cursor_y_in  input  NUM_CURSORS*V_WIDTH  packed y, same packing.
- cursor_rgb_in  input  NUM_CURSORS*24  packed {r,g,b} per cursor.
- cursor_en_in  input  NUM_CURSORS  per-cursor enable.
- mode_in  input  2  shape: 00 full lines, 01 short crosshair, 10 box, 11 off.
- blink_en_in  input  1  enables blinking.
- red_out, green_out, blue_out  output  8 each  composited pixel.
- ad_out, hs_out, vs_out  output  1 each  timing aligned to the pixel outputs.

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - All outputs 0.
  - Shadow registers 0, so all cursors are disabled and mode is 00.
  - Frame counter 0; blink phase = visible.
  - Pipeline registers 0.
- Shadow capture:
  - On any rising edge with nf_in=1, latch cursor_x/y/rgb/en, mode_in and blink_en_in into shadow registers.
  - All hit logic uses shadow values only, so input changes mid-frame never tear the overlay.
- Latency: fixed 2 cycles from every input to every output, including ad/hs/vs. Each delayed signal is a plain 2-register shift.
- Stage 1, registered per cursor i:
  - dx = |hcount − x_i| and dy = |vcount − y_i|, computed in (width+1)-bit unsigned.
  - Absolute difference only; no wrap-around, so a cursor at 0 or at the maximum coordinate draws only on-screen pixels.
  - hit_i = en_i AND shape(dx,dy) AND blink_visible.
- Shape rules:
  - Full: dx<=T OR dy<=T.
  - Short: (dx<=T AND dy<=L) OR (dy<=T AND dx<=L).
  - Box: dx<=L AND dy<=L AND (dx>=L−T OR dy>=L−T).
  - Off: no hit.
- Stage 2, registered:
  - Output the rgb of the lowest-index cursor with hit_i=1.
  - If no cursor hits, output the delayed background.
  - When delayed ad=0, force the rgb outputs to 0 regardless of hits.
- Blink:
  - The frame counter increments on each nf_in pulse.
  - At BLINK_FRAMES−1 it wraps to 0 and toggles the phase.
  - blink_visible = (shadow blink_en=0) OR phase.
  - The counter runs whether or not blinking is enabled.
  - If nf_in coincides with capture, the counter/phase update on the same edge; the new phase applies from the next cycle.
- Cursors of equal position: lower index wins.
- Reset mid-frame: outputs go to 0 immediately; pass-through resumes 2 cycles after release with the overlay disabled until the first nf_in.

Test Plan:
- Reset, no nf_in, background 0x123456 at all pixels → output 0x123456 after 2 cycles; ad/hs/vs match inputs delayed exactly 2 cycles.
- Cursor 0 en, x=100, y=50, rgb=0x0080FF, mode 00, T=1, nf pulse → pixels (99..101, any v) and (any h, 49..51) output 0x0080FF; (102,60) shows background.
- Mode 10, L=8, T=1, cursor at (200,100) → (192,100) and (207,93) hit; (200,100) and (206,100) miss; (209,100) misses.
- Cursor 0 and cursor 1 both at (10,10) with different colours → cursor 0 colour wins; disable cursor 0 with a new nf → cursor 1 colour.
- Change cursor_x_in mid-frame without nf → overlay unchanged until after the next nf_in pulse.
- blink_en=1, BLINK_FRAMES=2 → cursor visible 2 frames, hidden 2 frames, repeating; cursor at x=0, T=1 → only h=0..1 hit, no hit at h=1023.

Source files
------------

// File: rtl/cursor_overlay_pipe.sv
// Two-stage cursor compositor placed between the frame-buffer RGB stream and
// the TMDS encoders. Cursor parameters are shadowed on the new-frame pulse, so
// the overlay never tears mid-frame. Stage 1 computes per-cursor hits.
// Stage 2 picks the winning colour and blanks the pixel outside active draw.
module cursor_overlay_pipe #(
  parameter int unsigned NUM_CURSORS  = 2,
  parameter int unsigned H_WIDTH      = 10,
  parameter int unsigned V_WIDTH      = 9,
  parameter int unsigned THICK        = 1,
  parameter int unsigned ARM_LEN      = 8,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                       clk_pixel_in,
  input  logic                       rst_n_in,
  input  logic [H_WIDTH-1:0]         hcount_in,
  input  logic [V_WIDTH-1:0]         vcount_in,
  input  logic                       ad_in,
  input  logic                       hs_in,
  input  logic                       vs_in,
  input  logic                       nf_in,
  input  logic [7:0]                 red_in,
  input  logic [7:0]                 green_in,
  input  logic [7:0]                 blue_in,
  input  logic [NUM_CURSORS*H_WIDTH-1:0] cursor_x_in,
  input  logic [NUM_CURSORS*V_WIDTH-1:0] cursor_y_in,
  input  logic [NUM_CURSORS*24-1:0]  cursor_rgb_in,
  input  logic [NUM_CURSORS-1:0]     cursor_en_in,
  input  logic [1:0]                 mode_in,
  input  logic                       blink_en_in,
  output logic [7:0]                 red_out,
  output logic [7:0]                 green_out,
  output logic [7:0]                 blue_out,
  output logic                       ad_out,
  output logic                       hs_out,
  output logic                       vs_out
);

  localparam int unsigned HW1   = H_WIDTH + 1;
  localparam int unsigned VW1   = V_WIDTH + 1;
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [HW1-1:0]   ThickH = HW1'(THICK);
  localparam logic [HW1-1:0]   ArmH   = HW1'(ARM_LEN);
  localparam logic [HW1-1:0]   InnerH = HW1'(ARM_LEN - THICK);
  localparam logic [VW1-1:0]   ThickV = VW1'(THICK);
  localparam logic [VW1-1:0]   ArmV   = VW1'(ARM_LEN);
  localparam logic [VW1-1:0]   InnerV = VW1'(ARM_LEN - THICK);

  // Shadow copies of the cursor configuration
  logic [NUM_CURSORS*H_WIDTH-1:0] sh_x_q, sh_x_d;
  logic [NUM_CURSORS*V_WIDTH-1:0] sh_y_q, sh_y_d;
  logic [NUM_CURSORS*24-1:0]      sh_rgb_q, sh_rgb_d;
  logic [NUM_CURSORS-1:0]         sh_en_q, sh_en_d;
  logic [1:0]                     sh_mode_q, sh_mode_d;
  logic                           sh_blink_en_q, sh_blink_en_d;

  // Blink state; phase 1 means visible
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             phase_q, phase_d;
  logic             blink_visible;

  // Stage 1
  logic [NUM_CURSORS-1:0]    hit_q, hit_d;
  logic [NUM_CURSORS*24-1:0] rgb_s1_q, rgb_s1_d;
  logic [23:0]               bg_s1_q, bg_s1_d;
  logic [2:0]                tim_s1_q, tim_s1_d;   // {ad, hs, vs}

  // Stage 2
  logic [23:0] pix_q, pix_d;
  logic [2:0]  tim_q, tim_d;

  // Per-cursor distance scratch
  logic [HW1-1:0] hx, cx, dx;
  logic [VW1-1:0] vy, cy, dy;
  logic           shape;

  // Shadow capture on the new-frame pulse
  always_comb begin
    sh_x_d        = sh_x_q;
    sh_y_d        = sh_y_q;
    sh_rgb_d      = sh_rgb_q;
    sh_en_d       = sh_en_q;
    sh_mode_d     = sh_mode_q;
    sh_blink_en_d = sh_blink_en_q;
    if (nf_in) begin
      sh_x_d        = cursor_x_in;
      sh_y_d        = cursor_y_in;
      sh_rgb_d      = cursor_rgb_in;
      sh_en_d       = cursor_en_in;
      sh_mode_d     = mode_in;
      sh_blink_en_d = blink_en_in;
    end
  end

  // Frame counter and blink phase; runs even when blinking is disabled
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (nf_in) begin
      if (fcnt_q == CntMax) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + CNT_W'(1);
      end
    end
  end

  assign blink_visible = ~sh_blink_en_q | phase_q;

  // Stage 1: absolute distances and shape test per cursor
  always_comb begin
    hit_d    = '0;
    hx       = {1'b0, hcount_in};
    vy       = {1'b0, vcount_in};
    cx       = '0;
    cy       = '0;
    dx       = '0;
    dy       = '0;
    shape    = 1'b0;
    rgb_s1_d = sh_rgb_q;
    bg_s1_d  = {red_in, green_in, blue_in};
    tim_s1_d = {ad_in, hs_in, vs_in};
    for (int unsigned i = 0; i < NUM_CURSORS; i++) begin
      cx = {1'b0, sh_x_q[i*H_WIDTH +: H_WIDTH]};
      cy = {1'b0, sh_y_q[i*V_WIDTH +: V_WIDTH]};
      // Plain absolute difference: no wrap, so edge cursors stay on-screen
      dx = (hx >= cx) ? (hx - cx) : (cx - hx);
      dy = (vy >= cy) ? (vy - cy) : (cy - vy);
      case (sh_mode_q)
        2'b00:   shape = (dx <= ThickH) || (dy <= ThickV);
        2'b01:   shape = ((dx <= ThickH) && (dy <= ArmV)) ||
                         ((dy <= ThickV) && (dx <= ArmH));
        2'b10:   shape = (dx <= ArmH) && (dy <= ArmV) &&
                         ((dx >= InnerH) || (dy >= InnerV));
        default: shape = 1'b0;
      endcase
      hit_d[i] = sh_en_q[i] & shape & blink_visible;
    end
  end

  // Stage 2: lowest-index hit wins; blank outside active draw
  always_comb begin
    pix_d = bg_s1_q;
    tim_d = tim_s1_q;
    for (int i = int'(NUM_CURSORS) - 1; i >= 0; i--) begin
      if (hit_q[i]) pix_d = rgb_s1_q[i*24 +: 24];
    end
    if (!tim_s1_q[2]) pix_d = '0;
  end

  // All state registers with asynchronous active-low reset
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sh_x_q        <= '0;
      sh_y_q        <= '0;
      sh_rgb_q      <= '0;
      sh_en_q       <= '0;
      sh_mode_q     <= '0;
      sh_blink_en_q <= 1'b0;
      fcnt_q        <= '0;
      phase_q       <= 1'b1;
      hit_q         <= '0;
      rgb_s1_q      <= '0;
      bg_s1_q       <= '0;
      tim_s1_q      <= '0;
      pix_q         <= '0;
      tim_q         <= '0;
    end else begin
      sh_x_q        <= sh_x_d;
      sh_y_q        <= sh_y_d;
      sh_rgb_q      <= sh_rgb_d;
      sh_en_q       <= sh_en_d;
      sh_mode_q     <= sh_mode_d;
      sh_blink_en_q <= sh_blink_en_d;
      fcnt_q        <= fcnt_d;
      phase_q       <= phase_d;
      hit_q         <= hit_d;
      rgb_s1_q      <= rgb_s1_d;
      bg_s1_q       <= bg_s1_d;
      tim_s1_q      <= tim_s1_d;
      pix_q         <= pix_d;
      tim_q         <= tim_d;
    end
  end

  assign red_out   = pix_q[23:16];
  assign green_out = pix_q[15:8];
  assign blue_out  = pix_q[7:0];
  assign ad_out    = tim_q[2];
  assign hs_out    = tim_q[1];
  assign vs_out    = tim_q[0];

endmodule
